// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake transmit arbiter.
package hs_pkg;

  // Handshake mode selectors for the TWO_PHASE parameter.
  localparam int HS_4PHASE = 0;
  localparam int HS_2PHASE = 1;

  // Transfer FSM states; ST_DROP is only reachable in 4-phase mode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } hs_state_e;

endpackage : hs_pkg

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; the last stage is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: flops are updated with non-blocking assignments so every stage
      // samples the previous value of its neighbour on the same edge.
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : bit_sync

// File: rtl/hs_tx_arbiter.sv
// Multi-channel transmit arbiter: per-channel one-deep holding buffers,
// round-robin grant, and a req/ack handshake towards an asynchronous
// destination domain in either 4-phase (level) or 2-phase (toggle) mode.
module hs_tx_arbiter
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TWO_PHASE   = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]            o_busy,
  output logic                         o_req,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(NUM_CH)-1:0]    o_ch,
  input  logic                         i_ack,
  output logic                         o_done,
  output logic [15:0]                  o_xfer_cnt
);

  localparam int              CH_W      = $clog2(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_V  = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam bit              IS_2PHASE = (TWO_PHASE == HS_2PHASE);

  hs_state_e             state_q, state_d;
  logic                  req_q, req_d;
  logic                  done_q;
  logic                  grant;
  logic                  complete;
  logic                  gnt_found;
  logic [CH_W-1:0]       gnt_idx;
  logic [CH_W:0]         cand;
  logic [CH_W-1:0]       ch_q;
  logic [CH_W-1:0]       last_grant_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] buf_q [NUM_CH];
  logic [NUM_CH-1:0]     busy_q, busy_d;
  logic [15:0]           cnt_q;
  logic                  ack_s;

  // The acknowledge arrives from another clock domain; only its synchronized copy is used.
  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_ack),
    .q     (ack_s)
  );

  // Round-robin search: first occupied channel after the last one served.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, last_grant_q} + (CH_W + 1)'(i);
      if (cand >= NUM_CH_V) cand = cand - NUM_CH_V;
      if (!gnt_found && busy_q[cand[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[CH_W-1:0];
      end
    end
  end

  // Transfer FSM next-state and handshake request decode.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    req_d    = req_q;
    grant    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The completion pulse cycle is a dead cycle: no back-to-back grant.
        if (!done_q && gnt_found) begin
          grant   = 1'b1;
          state_d = ST_REQ;
          req_d   = IS_2PHASE ? ~req_q : 1'b1;
        end
      end
      ST_REQ: begin
        if (IS_2PHASE) begin
          if (ack_s == req_q) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!ack_s) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy: set on capture into a free buffer, cleared when its transfer completes.
  always_comb begin
    busy_d = busy_q | i_valid;
    if (complete) busy_d[ch_q] = 1'b0;
  end

  // Control state, in-flight payload, grant pointer and completion counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= '0;
      data_q       <= '0;
      ch_q         <= '0;
      last_grant_q <= LAST_CH;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= complete;
      busy_q  <= busy_d;
      if (grant) begin
        data_q <= buf_q[gnt_idx];
        ch_q   <= gnt_idx;
      end
      if (complete) begin
        last_grant_q <= ch_q;
        cnt_q        <= cnt_q + 16'd1;
      end
    end
  end

  // Holding buffers load only when their channel is free.
  always_ff @(posedge i_clk) begin
    // NOTE: the payload storage has no reset; a buffer is only ever read after
    // a capture has written it, and busy_q (which is reset) guards that.
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_valid[c] && !busy_q[c]) buf_q[c] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_busy     = busy_q;
  assign o_req      = req_q;
  assign o_data     = data_q;
  assign o_ch       = ch_q;
  assign o_done     = done_q;
  assign o_xfer_cnt = cnt_q;

endmodule : hs_tx_arbiter
